ascon_word_packer: RTL and testbench
====================================

ASCON_WORD_PACKER -- requirements
Module: ascon_word_packer

Interface
REQ-001 SHALL provide parameter WORD_WIDTH, default 32, width of the bus-side input word.
REQ-002 SHALL provide parameter BLOCK_WIDTH, default 64, width of the core-side output block; the value SHALL equal 2*WORD_WIDTH.
REQ-003 SHALL provide parameter DEPTH, default 2, the number of block FIFO entries; the value SHALL be a power of two and at least 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 clear_i  input  1  synchronous flush of the half-filled block and of all FIFO entries.
REQ-008 word_i  input  WORD_WIDTH  bus word.
REQ-009 word_last_i  input  1  marks word_i as the final word of the message.
REQ-010 word_valid_i  input  1  word_i and word_last_i are valid.
REQ-011 word_ready_o  output  1  the packer accepts word_i in this cycle.
REQ-012 block_o  output  BLOCK_WIDTH  FIFO head block; feeds ascon_core data_i.
REQ-013 block_valid_o  output  1  block_o is valid; feeds ascon_core data_valid_i.
REQ-014 block_ready_i  input  1  consumer takes block_o; driven from ascon_core data_ready_o.
REQ-015 level_o  output  $clog2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-016 A word SHALL be accepted only in a cycle where word_valid_i and word_ready_o are both 1.
REQ-017 word_ready_o SHALL be 1 exactly when level_o < DEPTH. It SHALL depend only on registered state and SHALL have no combinational path from block_ready_i.
REQ-018 The assembler SHALL be an FSM with two states: EMPTY and HALF.
REQ-019 EMPTY, accepted word with word_last_i=0: store the word in block bits [BLOCK_WIDTH-1:WORD_WIDTH] and go to HALF.
REQ-020 EMPTY, accepted word with word_last_i=1: push {word, WORD_WIDTH'0} into the FIFO and stay in EMPTY.
REQ-021 HALF, accepted word: push {held word, word} into the FIFO and go to EMPTY; word_last_i is ignored in this case.
REQ-022 Block bit ordering SHALL be big-endian: the first word of a block occupies the MSBs.
REQ-023 The FIFO SHALL be a DEPTH-entry circular buffer with wrapping read and write pointers.
REQ-024 The FIFO SHALL NOT be overwritten when full; this is guaranteed by REQ-017.
REQ-025 A pop SHALL occur when block_valid_o and block_ready_i are both 1.
REQ-026 block_valid_o SHALL equal (level_o != 0).
REQ-027 block_o SHALL hold the head entry and SHALL be stable while block_valid_o=1 and block_ready_i=0.
REQ-028 Latency: a push at rising edge N SHALL make block_valid_o=1 from edge N onward when the FIFO was empty, i.e. the block is visible in the cycle after the completing word.
REQ-029 Simultaneous push and pop SHALL leave level_o unchanged.
REQ-030 A simultaneous push and pop while level_o=DEPTH SHALL not occur, because word_ready_o=0 when the FIFO is full.
REQ-031 Sustained throughput SHALL be one block per two accepted words with no bubbles, provided block_ready_i stays 1.
REQ-032 clear_i=1 SHALL set the FSM to EMPTY, both pointers to 0 and level_o to 0 at the next edge.
REQ-033 clear_i SHALL take priority over a simultaneous accept or pop; any word offered in that cycle is discarded.
REQ-034 block_o SHALL NOT contain X after reset; the storage resets to 0.

Reset
REQ-035 When rst=1, the FSM SHALL go to EMPTY, the pointers and level_o to 0, and the held word and all FIFO entries to 0.
REQ-036 After reset, the outputs SHALL be: block_valid_o=0, block_o=0, word_ready_o=1, level_o=0.
REQ-037 rst asserted mid-message SHALL discard any partial block without emitting it.
REQ-038 rst SHALL take priority over clear_i and over all handshakes.

Configuration
REQ-039 The macro ASCON_PACKER_BYTESWAP_EN SHALL control byte order inside each accepted word.
REQ-040 With ASCON_PACKER_BYTESWAP_EN defined, each accepted word SHALL be byte-reversed before storage, converting a little-endian bus to Ascon big-endian order.
REQ-041 Without ASCON_PACKER_BYTESWAP_EN, words SHALL be stored unmodified; no swap logic is present.

Verification
REQ-042 After reset, send words 0x01234567 and then 0x89ABCDEF (last=0) with block_ready_i=1 -> one block 0x0123456789ABCDEF, block_valid_o high for one cycle, level_o returns to 0.
REQ-043 Single word 0xDEADBEEF with last=1 -> block 0xDEADBEEF00000000; the FSM stays in EMPTY.
REQ-044 block_ready_i=0 while 6 words are sent -> word_ready_o drops after the 4th word (level_o=2); then block_ready_i=1 -> blocks pop in order, and words 5 and 6 are accepted and form the 3rd block.
REQ-045 With level_o=1, a push and a pop in the same cycle -> level_o stays 1 and blocks keep their order.
REQ-046 With the FSM in HALF and level_o=1, assert clear_i together with word_valid_i -> next cycle level_o=0, block_valid_o=0, the word is dropped, and the next word starts a fresh block.
REQ-047 With ASCON_PACKER_BYTESWAP_EN defined, words 0x67452301 and 0xEFCDAB89 -> block 0x0123456789ABCDEF.

Source files
------------

// File: rtl/ascon_word_packer.sv
// ascon_word_packer
// Packs pairs of bus words into Ascon blocks and buffers them in a small FIFO.
// The first word of a block lands in the MSBs (big-endian block order). A word
// flagged as last while no half block is held is padded with zeros in the LSBs.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   clear_i        synchronous flush of the half block and all FIFO entries
//   word_i         bus word (WORD_WIDTH)
//   word_last_i    word_i is the final word of the message
//   word_valid_i   word_i / word_last_i valid
//   word_ready_o   packer accepts a word this cycle (level_o < DEPTH)
//   block_o        FIFO head block (BLOCK_WIDTH)
//   block_valid_o  block_o valid (level_o != 0)
//   block_ready_i  consumer takes block_o
//   level_o        occupied FIFO entries
//
// Build option:
//   ASCON_PACKER_BYTESWAP_EN  byte-reverse each accepted word before storage
//                             (little-endian bus to Ascon big-endian order).
module ascon_word_packer #(
  parameter int WORD_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 64,
  parameter int DEPTH       = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic [WORD_WIDTH-1:0]      word_i,
  input  logic                       word_last_i,
  input  logic                       word_valid_i,
  output logic                       word_ready_o,
  output logic [BLOCK_WIDTH-1:0]     block_o,
  output logic                       block_valid_o,
  input  logic                       block_ready_i,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   held_q, held_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [BLOCK_WIDTH-1:0]  mem_q [DEPTH];

  logic                    accept_s;
  logic                    push_s;
  logic                    pop_s;
  logic [BLOCK_WIDTH-1:0]  push_block_s;
  logic [WORD_WIDTH-1:0]   word_store_s;

`ifdef ASCON_PACKER_BYTESWAP_EN
  // Reverse byte order of one bus word.
  function automatic logic [WORD_WIDTH-1:0] byte_swap(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WORD_WIDTH / 8; b++) begin
      r[8*b +: 8] = w[WORD_WIDTH-8-8*b +: 8];
    end
    return r;
  endfunction

  assign word_store_s = byte_swap(word_i);
`else
  assign word_store_s = word_i;
`endif

  // Ready and valid come straight from the level register, so there is no
  // combinational path from block_ready_i to word_ready_o.
  assign word_ready_o  = (level_q != FULL_LVL);
  assign block_valid_o = (level_q != {LVL_W{1'b0}});
  assign block_o       = mem_q[rd_ptr_q];
  assign level_o       = level_q;

  // Handshake decode, block assembly and next-state computation.
  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    push_s       = 1'b0;
    push_block_s = {BLOCK_WIDTH{1'b0}};
    accept_s     = word_valid_i & word_ready_o;
    pop_s        = block_valid_o & block_ready_i;

    if (clear_i) begin
      // Flush wins over any handshake in the same cycle.
      accept_s = 1'b0;
      pop_s    = 1'b0;
      state_d  = ST_EMPTY;
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      level_d  = {LVL_W{1'b0}};
    end else begin
      if (accept_s) begin
        case (state_q)
          ST_EMPTY: begin
            if (word_last_i) begin
              push_s       = 1'b1;
              push_block_s = {word_store_s, {WORD_WIDTH{1'b0}}};
              state_d      = ST_EMPTY;
            end else begin
              held_d  = word_store_s;
              state_d = ST_HALF;
            end
          end
          ST_HALF: begin
            push_s       = 1'b1;
            push_block_s = {held_q, word_store_s};
            state_d      = ST_EMPTY;
          end
          default: begin
            state_d = ST_EMPTY;
          end
        endcase
      end else begin
        state_d = state_q;
      end

      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Assembler FSM, held word, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      held_q   <= {WORD_WIDTH{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage; zeroed on reset so block_o is never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {BLOCK_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_block_s;
    end
  end

endmodule

// File: tb/tb_ascon_word_packer.sv
// tb_ascon_word_packer
// Directed bench for ascon_word_packer (WORD_WIDTH=32, BLOCK_WIDTH=64, DEPTH=2).
// Inputs change and outputs are sampled on the falling edge.
// Build option ASCON_PACKER_BYTESWAP_EN: bus words are presented byte-reversed
// so the same big-endian block expectations hold in both builds.
module tb_ascon_word_packer;

  logic        clk;
  logic        rst;
  logic        clear_i;
  logic [31:0] word_i;
  logic        word_last_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [63:0] block_o;
  logic        block_valid_o;
  logic        block_ready_i;
  logic [1:0]  level_o;

  int tests_run;
  int tests_failed;

  ascon_word_packer #(
    .WORD_WIDTH  (32),
    .BLOCK_WIDTH (64),
    .DEPTH       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear_i),
    .word_i        (word_i),
    .word_last_i   (word_last_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .block_o       (block_o),
    .block_valid_o (block_valid_o),
    .block_ready_i (block_ready_i),
    .level_o       (level_o)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus encoding of a big-endian word for the active build.
  function automatic logic [31:0] bus_word(input logic [31:0] w);
`ifdef ASCON_PACKER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one word for a single edge, then drop valid.
  task automatic send(input logic [31:0] w, input logic last);
    word_i       = bus_word(w);
    word_last_i  = last;
    word_valid_i = 1'b1;
    tick();
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    clear_i       = 1'b0;
    word_i        = 32'h0000_0000;
    word_last_i   = 1'b0;
    word_valid_i  = 1'b0;
    block_ready_i = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check_eq("rst_valid", {63'd0, block_valid_o}, 64'd0);
    check_eq("rst_block", block_o, 64'd0);
    check_eq("rst_ready", {63'd0, word_ready_o}, 64'd1);
    check_eq("rst_level", {62'd0, level_o}, 64'd0);

    // Two words form one block that pops immediately.
    block_ready_i = 1'b1;
    send(32'h0123_4567, 1'b0);
    check_eq("pair_half_valid", {63'd0, block_valid_o}, 64'd0);
    send(32'h89AB_CDEF, 1'b0);
    check_eq("pair_valid", {63'd0, block_valid_o}, 64'd1);
    check_eq("pair_block", block_o, 64'h0123_4567_89AB_CDEF);
    tick();
    check_eq("pair_popped_level", {62'd0, level_o}, 64'd0);
    check_eq("pair_popped_valid", {63'd0, block_valid_o}, 64'd0);

    // Single last word is zero padded.
    block_ready_i = 1'b0;
    send(32'hDEAD_BEEF, 1'b1);
    check_eq("last_block", block_o, 64'hDEAD_BEEF_0000_0000);
    check_eq("last_level", {62'd0, level_o}, 64'd1);
    block_ready_i = 1'b1;
    tick();
    check_eq("last_popped_level", {62'd0, level_o}, 64'd0);

    // Back-pressure: FIFO fills after four words, then drains in order.
    block_ready_i = 1'b0;
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b0);
    check_eq("bp_ready_lvl1", {63'd0, word_ready_o}, 64'd1);
    send(32'h4444_4444, 1'b0);
    check_eq("bp_full_ready", {63'd0, word_ready_o}, 64'd0);
    check_eq("bp_full_level", {62'd0, level_o}, 64'd2);
    word_i       = bus_word(32'h5555_5555);
    word_valid_i = 1'b1;
    tick();
    check_eq("bp_stall_level", {62'd0, level_o}, 64'd2);
    check_eq("bp_head1", block_o, 64'h1111_1111_2222_2222);
    block_ready_i = 1'b1;
    tick();
    check_eq("bp_head2", block_o, 64'h3333_3333_4444_4444);
    check_eq("bp_level_after_pop1", {62'd0, level_o}, 64'd1);
    tick();
    check_eq("bp_level_after_pop2", {62'd0, level_o}, 64'd0);
    word_i = bus_word(32'h6666_6666);
    tick();
    word_valid_i = 1'b0;
    check_eq("bp_head3", block_o, 64'h5555_5555_6666_6666);
    check_eq("bp_level3", {62'd0, level_o}, 64'd1);
    tick();
    check_eq("bp_drained", {62'd0, level_o}, 64'd0);

    // Push and pop in the same cycle at level 1.
    block_ready_i = 1'b0;
    send(32'hA1A1_A1A1, 1'b0);
    send(32'hA2A2_A2A2, 1'b0);
    send(32'hA3A3_A3A3, 1'b0);
    check_eq("pp_level_before", {62'd0, level_o}, 64'd1);
    block_ready_i = 1'b1;
    send(32'hA4A4_A4A4, 1'b0);
    check_eq("pp_level_same", {62'd0, level_o}, 64'd1);
    check_eq("pp_head", block_o, 64'hA3A3_A3A3_A4A4_A4A4);
    tick();
    check_eq("pp_drained", {62'd0, level_o}, 64'd0);

    // Clear in HALF with a stored block and a word on the bus.
    block_ready_i = 1'b0;
    send(32'hC1C1_C1C1, 1'b0);
    send(32'hC2C2_C2C2, 1'b0);
    send(32'hC3C3_C3C3, 1'b0);
    clear_i = 1'b1;
    send(32'hC4C4_C4C4, 1'b0);
    clear_i = 1'b0;
    check_eq("clr_level", {62'd0, level_o}, 64'd0);
    check_eq("clr_valid", {63'd0, block_valid_o}, 64'd0);
    check_eq("clr_ready", {63'd0, word_ready_o}, 64'd1);
    send(32'hC5C5_C5C5, 1'b0);
    check_eq("clr_fresh_half", {62'd0, level_o}, 64'd0);
    send(32'hC6C6_C6C6, 1'b0);
    check_eq("clr_fresh_block", block_o, 64'hC5C5_C5C5_C6C6_C6C6);
    check_eq("clr_fresh_level", {62'd0, level_o}, 64'd1);

    // Reset mid-message discards partial and stored blocks.
    send(32'hD1D1_D1D1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_level", {62'd0, level_o}, 64'd0);
    check_eq("mrst_block", block_o, 64'd0);
    send(32'hD2D2_D2D2, 1'b1);
    check_eq("mrst_new_block", block_o, 64'hD2D2_D2D2_0000_0000);
    check_eq("mrst_new_level", {62'd0, level_o}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
